// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_stage_lsu_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = XLEN / 8;

    typedef logic [XLEN-1:0] data_t;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} lsu_state_t;

    // Access size from funct3; unsigned variants only exist for loads, anything unknown is a word.
    function automatic size_e access_size(input logic is_store, input logic [2:0] f3);
        size_e sz;
        case (f3)
            F3_B:    sz = SZ_B;
            F3_H:    sz = SZ_H;
            F3_BU:   sz = is_store ? SZ_W : SZ_B;
            F3_HU:   sz = is_store ? SZ_W : SZ_H;
            default: sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Extracts the addressed byte/half from a raw load word and sign-/zero-extends it.
// Latency: purely combinational.
// Backpressure: none.
module load_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane select by byte offset, then extend according to the load flavour.
    always_comb begin
        sel_byte = rdata[7:0];
        case (off)
            2'd0: sel_byte = rdata[7:0];
            2'd1: sel_byte = rdata[15:8];
            2'd2: sel_byte = rdata[23:16];
            2'd3: sel_byte = rdata[31:24];
            default: sel_byte = rdata[7:0];
        endcase
        // A halfword only looks at off[1]; a set off[0] is either trapped upstream or ignored.
        sel_half = off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    result = {{(XLEN-8){sel_byte[7]}}, sel_byte};
            F3_H:    result = {{(XLEN-16){sel_half[15]}}, sel_half};
            F3_BU:   result = {{(XLEN-8){1'b0}}, sel_byte};
            F3_HU:   result = {{(XLEN-16){1'b0}}, sel_half};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/gnt/rvalid handshake with data memory, store lane steering, load alignment.
// Latency: load stalls >=3 cycles (IDLE,REQ,WAIT), store >=2; one DONE cycle with stall=0 releases the pipe.
// Backpressure: stall held while waiting on mem_gnt/mem_rvalid; LSU_MISALIGN_TRAP_EN adds a misaligned trap.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [XLEN-1:0]   instr_in,
    input  logic [XLEN-1:0]   addr_in,
    input  logic [XLEN-1:0]   store_data_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [XLEN-1:0]   mem_data_out,
    output logic              stall
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic              misaligned
`endif
);

    lsu_state_t        state;
    instr_t            instr;
    logic              is_load;
    logic              is_store;
    logic              mem_op;
    size_e             size;
    logic [1:0]        off;
    logic [STRB_W-1:0] lane_strb;
    logic [XLEN-1:0]   lane_wdata;
    logic [2:0]        req_f3;
    logic [1:0]        req_off;
    logic [XLEN-1:0]   aligned;
    logic              unused_instr_bits;

    assign instr             = instr_t'(instr_in);
    assign off               = addr_in[1:0];
    assign unused_instr_bits = ^{instr.funct7, instr.rs2, instr.rs1, instr.rd};

    // Decode the incoming instruction and build the store lane image and byte enables.
    always_comb begin
        is_load  = valid_in && (instr.opcode == OPC_LOAD);
        is_store = valid_in && (instr.opcode == OPC_STORE);
        mem_op   = is_load || is_store;
        size     = access_size(is_store, instr.funct3);
        case (size)
            SZ_B: begin
                lane_strb  = STRB_W'(1) << off;
                lane_wdata = {(XLEN/8){store_data_in[7:0]}};
            end
            SZ_H: begin
                lane_strb  = off[1] ? STRB_W'(4'b1100) : STRB_W'(4'b0011);
                lane_wdata = {(XLEN/16){store_data_in[15:0]}};
            end
            default: begin
                lane_strb  = '1;
                lane_wdata = store_data_in;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis;
    // Halfwords need even addresses, words need 4-byte alignment.
    always_comb begin
        mis = ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
    end
`endif

    // Upstream only advances once the access has finished (DONE) or been abandoned (DRAIN).
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:      stall = mem_op && !flush;
            REQ, WAIT: stall = 1'b1;
            default:   stall = 1'b0;
        endcase
    end

    load_align u_load_align (
        .rdata  (mem_rdata),
        .off    (req_off),
        .funct3 (req_f3),
        .result (aligned)
    );

    // Access sequencer: captures the request in IDLE and walks the memory handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            mem_data_out <= '0;
            req_f3       <= '0;
            req_off      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op && !flush) begin
`ifdef LSU_MISALIGN_TRAP_EN
                        if (mis) begin
                            state      <= DONE;
                            misaligned <= 1'b1;
                        end else
`endif
                        begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr_in[XLEN-1:2], 2'b00};
                            mem_wdata <= is_store ? lane_wdata : '0;
                            mem_wstrb <= lane_strb;
                            req_f3    <= instr.funct3;
                            req_off   <= off;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        // Once granted the access is committed; a flush only decides what follows.
                        mem_req <= 1'b0;
                        if (mem_we) state <= flush ? IDLE : DONE;
                        else        state <= flush ? DRAIN : WAIT;
                    end else if (flush) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state <= mem_rvalid ? IDLE : DRAIN;
                    end else if (mem_rvalid) begin
                        mem_data_out <= aligned;
                        state        <= DONE;
                    end
                end
                DONE: begin
`ifdef LSU_MISALIGN_TRAP_EN
                    misaligned <= 1'b0;
`endif
                    state <= IDLE;
                end
                DRAIN: begin
                    if (mem_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: per-cycle compare against transaction-level expectations.
// Latency: n/a.
// Backpressure: bench plays memory with programmable grant and response delays.
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] instr_in = '0;
    logic [31:0] addr_in = '0;
    logic [31:0] store_data_in = '0;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_req, mem_we, stall;
    logic [31:0] mem_addr, mem_wdata, mem_data_out;
    logic [3:0]  mem_wstrb;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misaligned;
    logic        e_mis = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    int nstall = 0;
    int n0;
    bit chk_en = 1'b0;

    logic        e_req = 0, e_we = 0, e_stall = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, e_data = 0;
    logic [3:0]  e_wstrb = 0;

    mem_stage_lsu dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .valid_in      (valid_in),
        .instr_in      (instr_in),
        .addr_in       (addr_in),
        .store_data_in (store_data_in),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .mem_data_out  (mem_data_out),
        .stall         (stall)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .misaligned    (misaligned)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task step;
        @(posedge clk);
        #1;
    endtask

    // ---- reference model: access rules in plain arithmetic ----
    function automatic int size_of(input bit st, input logic [2:0] f3);
        if (f3 == 3'd0) return 1;
        if (f3 == 3'd1) return 2;
        if (!st && f3 == 3'd4) return 1;
        if (!st && f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] m_strb(input int sz, input logic [1:0] off);
        if (sz == 1) return 4'(1 << off);
        if (sz == 2) return 4'(3 << (2 * off[1]));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] sd);
        if (sz == 1) return 32'(sd[7:0]) * 32'h01010101;
        if (sz == 2) return 32'(sd[15:0]) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
        int sz;
        logic [31:0] v;
        sz = size_of(1'b0, f3);
        if (sz == 1) begin
            v = (rd >> (8 * off)) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2) begin
            v = (rd >> (16 * off[1])) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [31:0] mk_instr(input bit st, input logic [2:0] f3);
        return {7'd0, 5'd2, 5'd1, f3, 5'd3, (st ? 7'b0100011 : 7'b0000011)};
    endfunction

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req", 32'(mem_req), 32'(e_req));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
            chk("stall", 32'(stall), 32'(e_stall));
            chk("mem_data_out", mem_data_out, e_data);
`ifdef LSU_MISALIGN_TRAP_EN
            chk("misaligned", 32'(misaligned), 32'(e_mis));
`endif
            if (stall === 1'b1) nstall++;
        end
    end

    // One memory transaction: gd = grant delay, rd = response delay, fl = flush in first WAIT cycle.
    task automatic op(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                      input int gd, input int rd, input logic [31:0] rdata, input bit fl);
        int sz;
        sz = size_of(st, f3);
        valid_in      = 1'b1;
        instr_in      = mk_instr(st, f3);
        addr_in       = a;
        store_data_in = sd;
        e_stall       = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00)) begin
            step;
            e_stall = 1'b0;
            e_mis   = 1'b1;
            step;
            e_mis    = 1'b0;
            valid_in = 1'b0;
            return;
        end
`endif
        step;
        e_req   = 1'b1;
        e_we    = st;
        e_addr  = {a[31:2], 2'b00};
        e_wstrb = m_strb(sz, a[1:0]);
        e_wdata = st ? m_wdata(sz, sd) : 32'd0;
        repeat (gd) step;
        mem_gnt = 1'b1;
        step;
        mem_gnt = 1'b0;
        e_req   = 1'b0;
        if (st) begin
            e_stall = 1'b0;
            step;
            valid_in = 1'b0;
            return;
        end
        if (fl) begin
            flush = 1'b1;
            step;
            flush    = 1'b0;
            valid_in = 1'b0;
            e_stall  = 1'b0;
            repeat (rd - 1) step;
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            step;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            return;
        end
        repeat (rd) step;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        step;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        e_data     = m_load(f3, a[1:0], rdata);
        e_stall    = 1'b0;
        step;
        valid_in = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] lf3 [8];
        logic [6:0] nonmem [4];
        lf3    = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        nonmem = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

        // Reset state
        step;
        chk_en = 1'b1;
        step;
        step;
        rst = 1'b0;
        step;

        // Non-memory instruction and invalid load never stall
        valid_in = 1'b1;
        instr_in = {25'd0, 7'b0110011};
        step;
        step;
        valid_in = 1'b0;
        instr_in = mk_instr(1'b0, 3'd2);
        step;

        // Directed transactions with literal expectations
        n0 = nstall;
        op(1'b0, 3'd2, 32'h100, 32'd0, 0, 0, 32'hDEADBEEF, 1'b0);
        chk("lw_stall_cycles", 32'(nstall - n0), 32'd3);
        chk("lw_addr", mem_addr, 32'h100);
        chk("lw_data", mem_data_out, 32'hDEADBEEF);
        op(1'b0, 3'd0, 32'h103, 32'd0, 0, 1, 32'h80123456, 1'b0);
        chk("lb_data", mem_data_out, 32'hFFFFFF80);
        op(1'b0, 3'd4, 32'h103, 32'd0, 1, 0, 32'h80123456, 1'b0);
        chk("lbu_data", mem_data_out, 32'h00000080);
        op(1'b0, 3'd5, 32'h102, 32'd0, 0, 2, 32'h80123456, 1'b0);
        chk("lhu_data", mem_data_out, 32'h00008012);
        n0 = nstall;
        op(1'b1, 3'd0, 32'h41, 32'h0000005A, 0, 0, 32'd0, 1'b0);
        chk("sb_stall_cycles", 32'(nstall - n0), 32'd2);
        chk("sb_wdata", mem_wdata, 32'h5A5A5A5A);
        chk("sb_wstrb", 32'(mem_wstrb), 32'h2);
        op(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 2, 0, 32'd0, 1'b0);
        chk("sh_addr", mem_addr, 32'h200);
        chk("sh_wdata", mem_wdata, 32'hABCDABCD);
        chk("sh_wstrb", 32'(mem_wstrb), 32'hC);
        op(1'b0, 3'd2, 32'h180, 32'd0, 0, 2, 32'h11111111, 1'b1);
        chk("flush_data_kept", mem_data_out, 32'h00008012);
`ifdef LSU_MISALIGN_TRAP_EN
        op(1'b0, 3'd2, 32'h101, 32'd0, 0, 0, 32'hCAFEF00D, 1'b0);
        chk("mis_data_kept", mem_data_out, 32'h00008012);
        chk("mis_addr_kept", mem_addr, 32'h180);
`else
        op(1'b0, 3'd2, 32'h101, 32'd0, 0, 0, 32'hCAFEF00D, 1'b0);
        chk("lw_unaligned_addr", mem_addr, 32'h100);
        chk("lw_unaligned_strb", 32'(mem_wstrb), 32'hF);
        chk("lw_unaligned_data", mem_data_out, 32'hCAFEF00D);
`endif

        // Flush while waiting for grant drops the request
        valid_in      = 1'b1;
        instr_in      = mk_instr(1'b1, 3'd2);
        addr_in       = 32'h300;
        store_data_in = 32'h77;
        e_stall       = 1'b1;
        step;
        e_req = 1'b1; e_we = 1'b1; e_addr = 32'h300; e_wdata = 32'h77; e_wstrb = 4'hF;
        flush = 1'b1;
        step;
        flush = 1'b0; valid_in = 1'b0; e_req = 1'b0; e_stall = 1'b0;
        step;

        // Reset in the middle of a request
        valid_in = 1'b1;
        instr_in = mk_instr(1'b0, 3'd2);
        addr_in  = 32'h3C4;
        e_stall  = 1'b1;
        step;
        e_req = 1'b1; e_we = 1'b0; e_addr = 32'h3C4; e_wdata = 32'd0; e_wstrb = 4'hF;
        rst = 1'b1;
        step;
        rst = 1'b0; valid_in = 1'b0;
        e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_wstrb = 0; e_stall = 0; e_data = 0;
        step;
        step;
        chk("rst_data", mem_data_out, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(7) == 0) begin
                valid_in = 1'b1;
                instr_in = {25'd0, nonmem[$urandom_range(3)]};
                step;
                valid_in = 1'b0;
            end else begin
                bit          st;
                logic [2:0]  f3;
                int          rdl;
                bit          fl;
                st  = 1'($urandom_range(1));
                f3  = st ? 3'($urandom_range(2)) : lf3[$urandom_range(7)];
                rdl = $urandom_range(3);
                fl  = !st && ($urandom_range(4) == 0);
                if (fl && rdl == 0) rdl = 1;
                op(st, f3, $urandom, $urandom, $urandom_range(3), rdl, $urandom, fl);
            end
        end
        step;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
